// File: rtl/ysyx_25040129_rd_arbiter_pkg.sv
// Shared definitions for the read-channel arbiter slice.
// Holds the arbiter state encoding, AXI response codes, the fixed IFU access
// size, master identifiers and a saturating increment for the wait counters.
package ysyx_25040129_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // The IFU always fetches full 32-bit words.
    localparam logic [2:0] IFU_ARSIZE = 3'b010;

    localparam logic MASTER_IFU = 1'b0;
    localparam logic MASTER_LSU = 1'b1;

    function automatic logic [3:0] sat_inc(input logic [3:0] value);
        return (value == 4'hF) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/ysyx_25040129_rr_pick.sv
// Winner selection for a two-master arbiter, reusable by the write channel.
// Ports:
//   clk, rst     clock and asynchronous active-low reset
//   req[1:0]     request vector (bit 0 = IFU, bit 1 = LSU)
//   grant        high in the cycle the owner decides; state updates then
//   winner       combinational winner for the current request vector
// Registered state: last_served and one 4-bit saturating wait counter per master.
module ysyx_25040129_rr_pick
    import ysyx_25040129_rd_arbiter_pkg::*;
#(
    parameter bit LSU_PRIO = 1'b1,
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant,
    output logic       winner
);

    logic       last_served;
    logic [3:0] wait_cnt [2];
    logic       both;
    logic       pref;

    assign both = req[0] & req[1];

    // A starved loser overrides the normal preference once it has lost
    // MAX_WAIT contested arbitrations in a row.
    always_comb begin
        pref   = LSU_PRIO ? MASTER_LSU : ~last_served;
        winner = req[1];
        if (both) begin
            winner = (wait_cnt[~pref] >= 4'(MAX_WAIT)) ? ~pref : pref;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_served <= MASTER_LSU;
            wait_cnt[0] <= '0;
            wait_cnt[1] <= '0;
        end else if (grant && (|req)) begin
            last_served      <= winner;
            wait_cnt[winner] <= '0;
            if (both) begin
                wait_cnt[~winner] <= sat_inc(wait_cnt[~winner]);
            end
        end
    end

endmodule

// File: rtl/ysyx_25040129_rd_arbiter.sv
// Two-master, one-slave AXI4-Lite read (AR/R) arbiter: IFU (master 0) and
// LSU (master 1) share one memory read port, one transaction at a time.
// Ports:
//   clk, rst             clock and asynchronous active-low reset
//   ifu_ar*/ifu_r*       IFU read address / data channels
//   lsu_ar*/lsu_r*       LSU read address / data channels
//   m_ar*/m_r*           shared slave read port
//   owner                current/last owner (0 = IFU, 1 = LSU), debug only
// The data path is pure routing, so it adds no latency.
module ysyx_25040129_rd_arbiter
    import ysyx_25040129_rd_arbiter_pkg::*;
#(
    parameter bit LSU_PRIO = 1'b1,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    input  logic [31:0] lsu_araddr,
    input  logic [2:0]  lsu_arsize,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    output logic [31:0] m_araddr,
    output logic [2:0]  m_arsize,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic        owner
);

    arb_state_t state;
    logic       winner;
    logic       ar_hs;
    logic       r_hs;

    ysyx_25040129_rr_pick #(
        .LSU_PRIO(LSU_PRIO),
        .MAX_WAIT(MAX_WAIT)
    ) u_pick (
        .clk   (clk),
        .rst   (rst),
        .req   ({lsu_arvalid, ifu_arvalid}),
        .grant (state == ST_IDLE),
        .winner(winner)
    );

    assign ar_hs = m_arvalid & m_arready;
    assign r_hs  = m_rvalid & m_rready;

    // The grant is held from arbitration through the R handshake; a slave
    // may complete both handshakes in the ADDR cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            owner <= MASTER_IFU;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ifu_arvalid || lsu_arvalid) begin
                        owner <= winner;
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (ar_hs && r_hs) begin
                        state <= ST_IDLE;
                    end else if (ar_hs) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_hs) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // AR is routed only in ADDR; R is routed in ADDR and DATA so that a
    // same-cycle response reaches the owner. The non-owner sees zeros.
    always_comb begin
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = RESP_OKAY;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = RESP_OKAY;
        lsu_rvalid  = 1'b0;
        m_araddr    = '0;
        m_arsize    = '0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        if (state == ST_ADDR) begin
            if (owner == MASTER_LSU) begin
                m_araddr    = lsu_araddr;
                m_arsize    = lsu_arsize;
                m_arvalid   = lsu_arvalid;
                lsu_arready = m_arready;
            end else begin
                m_araddr    = ifu_araddr;
                m_arsize    = IFU_ARSIZE;
                m_arvalid   = ifu_arvalid;
                ifu_arready = m_arready;
            end
        end
        if (state == ST_ADDR || state == ST_DATA) begin
            if (owner == MASTER_LSU) begin
                lsu_rdata  = m_rdata;
                lsu_rresp  = m_rresp;
                lsu_rvalid = m_rvalid;
                m_rready   = lsu_rready;
            end else begin
                ifu_rdata  = m_rdata;
                ifu_rresp  = m_rresp;
                ifu_rvalid = m_rvalid;
                m_rready   = ifu_rready;
            end
        end
    end

`ifndef SYNTHESIS
    // A response with no transaction in flight is dropped; flag it.
    always @(posedge clk) begin
        if (rst && state == ST_IDLE && m_rvalid) begin
            $error("rd_arbiter: m_rvalid seen in IDLE, response dropped");
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_25040129_rd_arbiter.sv
// Self-checking bench for ysyx_25040129_rd_arbiter.
// Two instances share all inputs: u_prio (LSU_PRIO=1) and u_rr (LSU_PRIO=0),
// both with MAX_WAIT=4. Both masters' rready come from one signal so the two
// instances always change state on the same cycles.
module tb_ysyx_25040129_rd_arbiter;

    typedef struct packed {
        logic        ifu_arready;
        logic [31:0] ifu_rdata;
        logic [1:0]  ifu_rresp;
        logic        ifu_rvalid;
        logic        lsu_arready;
        logic [31:0] lsu_rdata;
        logic [1:0]  lsu_rresp;
        logic        lsu_rvalid;
        logic [31:0] m_araddr;
        logic [2:0]  m_arsize;
        logic        m_arvalid;
        logic        m_rready;
        logic        owner;
    } outs_t;

    typedef struct {
        logic        iv;
        logic        lv;
        logic        mar;
        logic        mrv;
        logic [31:0] mrd;
        logic [1:0]  mrs;
        logic        rr;
        outs_t       exp;
    } vec_t;

    localparam logic [31:0] IFU_ADDR = 32'h8000_0000;
    localparam logic [31:0] LSU_ADDR = 32'h8000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic [31:0] lsu_araddr;
    logic [2:0]  lsu_arsize;
    logic        lsu_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        rready;
    outs_t       op;
    outs_t       orr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_25040129_rd_arbiter #(.LSU_PRIO(1'b1), .MAX_WAIT(4)) u_prio (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(op.ifu_arready),
        .ifu_rdata(op.ifu_rdata), .ifu_rresp(op.ifu_rresp), .ifu_rvalid(op.ifu_rvalid),
        .ifu_rready(rready),
        .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid),
        .lsu_arready(op.lsu_arready), .lsu_rdata(op.lsu_rdata), .lsu_rresp(op.lsu_rresp),
        .lsu_rvalid(op.lsu_rvalid), .lsu_rready(rready),
        .m_araddr(op.m_araddr), .m_arsize(op.m_arsize), .m_arvalid(op.m_arvalid),
        .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid),
        .m_rready(op.m_rready), .owner(op.owner)
    );

    ysyx_25040129_rd_arbiter #(.LSU_PRIO(1'b0), .MAX_WAIT(4)) u_rr (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(orr.ifu_arready),
        .ifu_rdata(orr.ifu_rdata), .ifu_rresp(orr.ifu_rresp), .ifu_rvalid(orr.ifu_rvalid),
        .ifu_rready(rready),
        .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid),
        .lsu_arready(orr.lsu_arready), .lsu_rdata(orr.lsu_rdata), .lsu_rresp(orr.lsu_rresp),
        .lsu_rvalid(orr.lsu_rvalid), .lsu_rready(rready),
        .m_araddr(orr.m_araddr), .m_arsize(orr.m_arsize), .m_arvalid(orr.m_arvalid),
        .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid),
        .m_rready(orr.m_rready), .owner(orr.owner)
    );

    function automatic outs_t mk_exp(
        input logic ow, input logic iar, input logic lar, input logic mav, input logic mrr,
        input logic [31:0] addr, input logic [2:0] sz, input logic irv, input logic lrv,
        input logic [31:0] ird, input logic [31:0] lrd, input logic [1:0] irs,
        input logic [1:0] lrs);
        outs_t o;
        o.ifu_arready = iar;  o.ifu_rdata = ird;  o.ifu_rresp = irs;  o.ifu_rvalid = irv;
        o.lsu_arready = lar;  o.lsu_rdata = lrd;  o.lsu_rresp = lrs;  o.lsu_rvalid = lrv;
        o.m_araddr = addr;    o.m_arsize = sz;    o.m_arvalid = mav;  o.m_rready = mrr;
        o.owner = ow;
        return o;
    endfunction

    task automatic check_output(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic apply_stimulus(input logic iv, input logic lv, input logic mar,
                                  input logic mrv, input logic [31:0] mrd,
                                  input logic [1:0] mrs, input logic rr);
        @(negedge clk);
        ifu_arvalid = iv;
        lsu_arvalid = lv;
        m_arready   = mar;
        m_rvalid    = mrv;
        m_rdata     = mrd;
        m_rresp     = mrs;
        rready      = rr;
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; m_arready = 1'b0;
        m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; rready = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One arbitration cycle followed by an ADDR cycle that completes both handshakes.
    task automatic run_txn(input logic use_rr, input logic iv, input logic lv,
                           input logic exp_owner, input string name);
        logic [31:0] exp_addr;
        exp_addr = exp_owner ? LSU_ADDR : IFU_ADDR;
        apply_stimulus(iv, lv, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
        apply_stimulus(iv, lv, 1'b1, 1'b1, 32'h0000_0123, 2'b00, 1'b1);
        if (use_rr) begin
            check_output(name, 128'({orr.owner, orr.m_araddr}), 128'({exp_owner, exp_addr}));
        end else begin
            check_output(name, 128'({op.owner, op.m_araddr}), 128'({exp_owner, exp_addr}));
        end
    endtask

    vec_t vecs [11];

    initial begin
        // Columns: iv lv mar mrv mrd mrs rr | owner iar lar mav mrr addr size irv lrv ird lrd irs lrs
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1,
                     mk_exp(0, 0, 0, 0, 0, 32'h0, 3'd0, 0, 0, 32'h0, 32'h0, 2'd0, 2'd0)};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1,
                     mk_exp(0, 0, 0, 0, 0, 32'h0, 3'd0, 0, 0, 32'h0, 32'h0, 2'd0, 2'd0)};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h413, 2'd0, 1'b1,
                     mk_exp(0, 1, 0, 1, 1, IFU_ADDR, 3'd2, 1, 0, 32'h413, 32'h0, 2'd0, 2'd0)};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1,
                     mk_exp(0, 0, 0, 0, 0, 32'h0, 3'd0, 0, 0, 32'h0, 32'h0, 2'd0, 2'd0)};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1,
                     mk_exp(0, 0, 0, 0, 0, 32'h0, 3'd0, 0, 0, 32'h0, 32'h0, 2'd0, 2'd0)};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1,
                     mk_exp(1, 0, 1, 1, 1, LSU_ADDR, 3'd0, 0, 0, 32'h0, 32'h0, 2'd0, 2'd0)};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFE_0001, 2'd2, 1'b1,
                     mk_exp(1, 0, 0, 0, 1, 32'h0, 3'd0, 0, 1, 32'h0, 32'hCAFE_0001, 2'd0, 2'd2)};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1,
                     mk_exp(1, 0, 0, 0, 0, 32'h0, 3'd0, 0, 0, 32'h0, 32'h0, 2'd0, 2'd0)};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1,
                     mk_exp(0, 1, 0, 1, 1, IFU_ADDR, 3'd2, 0, 0, 32'h0, 32'h0, 2'd0, 2'd0)};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 2'd0, 1'b1,
                     mk_exp(0, 0, 0, 0, 1, 32'h0, 3'd0, 1, 0, 32'h11, 32'h0, 2'd0, 2'd0)};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1,
                     mk_exp(0, 0, 0, 0, 0, 32'h0, 3'd0, 0, 0, 32'h0, 32'h0, 2'd0, 2'd0)};

        ifu_araddr = IFU_ADDR; lsu_araddr = LSU_ADDR; lsu_arsize = 3'b000;
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; m_arready = 1'b0;
        m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; rready = 1'b1;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check_output("reset_prio", 128'(op), 128'(0));
        check_output("reset_rr", 128'(orr), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Directed table against the LSU-priority instance.
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].iv, vecs[i].lv, vecs[i].mar, vecs[i].mrv,
                           vecs[i].mrd, vecs[i].mrs, vecs[i].rr);
            check_output($sformatf("vec%0d", i), 128'(op), 128'(vecs[i].exp));
        end

        // Starvation: IFU loses four contested arbitrations, then wins the fifth.
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                check_output("ifu_wait_before", 128'(u_prio.u_pick.wait_cnt[0]), 128'(4));
            end
            run_txn(1'b0, 1'b1, 1'b1, (i == 4) ? 1'b0 : 1'b1, $sformatf("starve%0d", i));
            if (i == 4) begin
                check_output("ifu_wait_after", 128'(u_prio.u_pick.wait_cnt[0]), 128'(0));
            end
        end

        // Round-robin: grants alternate IFU, LSU, IFU, LSU from reset.
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 1'b1, 1'b1, (i % 2 == 1) ? 1'b1 : 1'b0, $sformatf("rr%0d", i));
        end

        // Slow slave: rvalid three cycles after arready, owner stalls two more.
        reset_dut();
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
        check_output("slow_ar", 128'({op.ifu_arready, op.m_arvalid}), 128'(2'b11));
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
            check_output($sformatf("slow_wait%0d", k),
                         128'({op.m_rready, op.ifu_rvalid, op.m_arvalid}), 128'(3'b100));
        end
        for (int k = 0; k < 2; k++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'd0, 1'b0);
            check_output($sformatf("slow_stall%0d", k),
                         128'({op.m_rready, op.ifu_rvalid, op.lsu_arready, op.owner, op.ifu_rdata}),
                         128'({4'b0100, 32'hDEAD_BEEF}));
        end
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'd0, 1'b1);
        check_output("slow_r_hs", 128'({op.m_rready, op.ifu_rvalid}), 128'(2'b11));
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
        check_output("slow_idle", 128'(op), 128'(0));
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
        check_output("slow_next", 128'({op.lsu_arready, op.owner, op.m_araddr}),
                     128'({2'b11, LSU_ADDR}));
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 2'd0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);

        // Asynchronous reset in the middle of an LSU data phase.
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h77, 2'd0, 1'b0);
        check_output("pre_reset", 128'({op.lsu_rvalid, op.owner, op.lsu_rdata}),
                     128'({2'b11, 32'h77}));
        #1 rst = 1'b0;
        #1;
        check_output("async_reset", 128'(op), 128'(0));
        m_rvalid = 1'b0; m_rdata = '0; rready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
        check_output("post_reset_arb", 128'(op), 128'(0));
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h99, 2'd0, 1'b1);
        check_output("post_reset_grant",
                     128'({op.owner, op.lsu_arready, op.lsu_rvalid, op.m_araddr, op.lsu_rdata}),
                     128'({3'b111, LSU_ADDR, 32'h99}));
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_25040129_rd_arbiter.md
Name: ysyx_25040129_rd_arbiter

Overview:
- Two-master, one-slave arbiter for the AXI4-Lite read channels (AR/R).
- Shares one memory read port between the instruction fetch unit (master 0) and the load/store unit (master 1).
- Sits between the IFU/LSU read ports and the memory/crossbar read port.
- Exactly one transaction is outstanding at a time. The grant is held from the AR handshake until the R handshake.
- A starvation counter bounds how long a losing master waits.

Parameters:
- LSU_PRIO, 1: 1 = LSU wins simultaneous requests; 0 = round-robin (the last-served master loses the tie).
- MAX_WAIT, 4: consecutive lost arbitrations after which the losing master is forced to win the next one. Range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- ifu_araddr  in  32  IFU read address
- ifu_arvalid  in  1  IFU address valid
- ifu_arready  out  1  IFU address accepted
- ifu_rdata  out  32  read data to IFU
- ifu_rresp  out  2  response to IFU
- ifu_rvalid  out  1  data valid to IFU
- ifu_rready  in  1  IFU ready for data
- lsu_araddr  in  32  LSU read address
- lsu_arsize  in  3  LSU access size
- lsu_arvalid  in  1  LSU address valid
- lsu_arready  out  1  LSU address accepted
- lsu_rdata  out  32  read data to LSU
- lsu_rresp  out  2  response to LSU
- lsu_rvalid  out  1  data valid to LSU
- lsu_rready  in  1  LSU ready for data
- m_araddr  out  32  address to slave
- m_arsize  out  3  size to slave; 3'b010 when IFU owns the port
- m_arvalid  out  1  address valid to slave
- m_arready  in  1  slave accepts address
- m_rdata  in  32  slave data
- m_rresp  in  2  slave response
- m_rvalid  in  1  slave data valid
- m_rready  out  1  ready to slave
- owner  out  1  current/last owner (0 = IFU, 1 = LSU); debug only

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, owner = 0, last_served = 1, wait counters = 0.
  - All valid/ready outputs are 0.
  - m_araddr, m_arsize and the data outputs are 0.
- States:
  - IDLE: no master routed; every arready, rvalid and m_* valid/ready output is 0. If any arvalid is high, decide the winner, register owner, go to ADDR. Arbitration costs one cycle.
  - ADDR: route the owner's araddr/arsize/arvalid to m_*, and m_arready to the owner's arready. The other master sees arready = 0.
    - m_arready && m_rvalid && the owner's rready in the same cycle: complete, go to IDLE.
    - m_arready only: go to DATA.
    - Otherwise hold.
  - DATA: route m_rdata/m_rresp/m_rvalid to the owner and the owner's rready to m_rready. Go to IDLE on m_rvalid && rready. The non-owner sees rvalid = 0 and its rdata/rresp are 0.
- R-channel routing by state:
  - In ADDR, the R channel is also routed to the owner. This supports slaves that return data in the arready cycle; the IFU asserts rready combinationally with arready.
  - In IDLE, m_rready is 0. Any m_rvalid seen in IDLE is dropped and flagged by a simulation-only $error.
- Winner decision (IDLE, both arvalid high):
  - If the loser's wait counter ≥ MAX_WAIT, the loser wins.
  - Otherwise, LSU_PRIO=1 → LSU wins; LSU_PRIO=0 → the master that is not last_served wins.
  - A single requester always wins.
- Wait counters (4 bits, saturating):
  - The losing master's counter increments in each cycle where both requested and it lost.
  - The winner's counter clears on grant.
- last_served updates on grant.
- An arvalid deassertion during ADDR is a master protocol violation. The arbiter still holds the grant until the AR handshake.
- Flush: the IFU keeps rready high in order to drain a killed fetch. The arbiter has no flush input and never aborts a transaction.
- rresp is passed through unmodified. The arbiter holds no data registers, so the data path adds zero latency.

Decomposition:
- Shared package/defines: state encodings (IDLE = 2'b00, ADDR = 2'b01, DATA = 2'b10); the OKAY/SLVERR response codes already in the global defines; the IFU fixed arsize 3'b010.
- Sub-module: ysyx_25040129_rr_pick. This is the combinational winner selection plus the registered wait counters and last_served. It is kept separate so it can be reused for the write-channel arbiter.

Test Plan:
- IFU alone, araddr=0x80000000; slave gives arready at cycle 2 and rvalid with rdata=0x00000413 in the same cycle → ifu_rvalid=1, ifu_rdata=0x00000413 in that cycle; state back to IDLE next cycle; lsu_* outputs stay 0.
- IFU and LSU request in the same cycle, LSU_PRIO=1, LSU araddr=0x80001000 arsize=3'b000 → m_araddr=0x80001000, m_arsize=0; IFU granted only after LSU's R handshake.
- LSU_PRIO=1, LSU requests continuously with MAX_WAIT=4 and IFU held → IFU wins the 5th contested arbitration; its counter clears to 0.
- LSU_PRIO=0, both requesting back-to-back → grants alternate IFU, LSU, IFU, LSU; owner toggles each transaction.
- Slave rvalid delayed 3 cycles after arready, owner rready low for 2 more cycles → m_rready follows the owner's rready; rdata is held by the slave until the handshake; no grant change.
- rst driven low mid-DATA → all outputs 0 asynchronously (before the next clk edge); after release the first request is arbitrated from IDLE normally.
